// File: rtl/wb_defs_pkg.sv
// Shared Wishbone B3 definitions: cycle-type / burst-type codes, FSM states, burst address step.
// Pure declarations and combinational helpers; no latency.
// No flow control of its own.
package wb_defs_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Next beat address: linear increments the whole word, wraps only the low field.
  function automatic logic [31:0] next_burst_adr(input logic [31:0] a, input logic [1:0] bte);
    logic [31:0] n;
    n = a;
    case (bte)
      BTE_WRAP4:  n[1:0] = a[1:0] + 2'd1;
      BTE_WRAP8:  n[2:0] = a[2:0] + 3'd1;
      BTE_WRAP16: n[3:0] = a[3:0] + 4'd1;
      default:    n = a + 32'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wb_ram_sp_be.sv
// Single-port RAM, Dw x 2**Aw, per-byte write enable.
// Read data registered: 1 cycle after the address is presented.
// Always ready; no backpressure.
module wb_ram_sp_be #(
  parameter int Dw = 32,
  parameter int Aw = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [Aw-1:0]     adr,
  input  logic [Dw/8-1:0]   we,
  input  logic [Dw-1:0]     wdat,
  output logic [Dw-1:0]     rdat
);

  logic [Dw-1:0] mem [2**Aw];

  // Byte-lane writes; the array itself carries no reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < Dw/8; b++) begin
      if (we[b]) mem[adr][b*8 +: 8] <= wdat[b*8 +: 8];
    end
  end

  // Registered read port; cleared on reset so the bus data output starts at zero.
  always_ff @(posedge clk) begin
    if (rst) rdat <= '0;
    else     rdat <= mem[adr];
  end

endmodule

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 registered-feedback RAM slave with classic, incrementing and wrapping bursts, plus write snoop.
// Ack/err one cycle after accept; bursts then stream one beat per cycle.
// Master throttles by dropping stb/cyc, which ends the burst; no wait states are inserted by the slave.
module wb_burst_ram_slave
  import wb_defs_pkg::*;
#(
  parameter int    Dw       = 32,
  parameter int    Aw       = 12,
  parameter string SNOOP_EN = "ENABLED"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       sa_adr_i,
  input  logic [Dw-1:0]     sa_dat_i,
  input  logic [Dw/8-1:0]   sa_sel_i,
  input  logic              sa_we_i,
  input  logic              sa_stb_i,
  input  logic              sa_cyc_i,
  input  logic [2:0]        sa_cti_i,
  input  logic [1:0]        sa_bte_i,
  output logic [Dw-1:0]     sa_dat_o,
  output logic              sa_ack_o,
  output logic              sa_err_o,
  output logic              sa_rty_o,
  output logic [31:0]       snoop_adr_o,
  output logic              snoop_en_o
);

  localparam bit SnoopOn = (SNOOP_EN != "NONE");

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       beat_adr_q, beat_adr_d;
  logic              snoop_en_q;
  logic [31:0]       snoop_adr_q;

  logic              req;
  logic              xfer;
  logic              commit;
  logic [31:0]       nxt_adr;
  logic [Aw-1:0]     ram_adr;
  logic [Dw/8-1:0]   ram_we;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, next ack/err/beat address and the RAM port address.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    beat_adr_d = beat_adr_q;
    req        = sa_cyc_i & sa_stb_i;
    xfer       = ack_q & req;
    // A write pending on a reset edge must not land in the RAM.
    commit     = xfer & sa_we_i & ~rst;
    nxt_adr    = next_burst_adr(beat_adr_q, sa_bte_i);
    ram_adr    = sa_adr_i[Aw-1:0];

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          beat_adr_d = sa_adr_i;
          state_d    = ST_ACK;
          if ((sa_adr_i >> Aw) != 32'd0) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (sa_cti_i == CTI_INC) state_d = ST_BURST;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (req && sa_cti_i == CTI_INC) begin
          if ((nxt_adr >> Aw) != 32'd0) begin
            // Linear burst ran off the top of RAM: error the next beat, then finish.
            err_d   = 1'b1;
            state_d = ST_ACK;
          end else begin
            ack_d      = 1'b1;
            beat_adr_d = nxt_adr;
            // Speculative read of the next beat.
            ram_adr    = nxt_adr[Aw-1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A committing write owns the single RAM port this cycle.
    if (commit) ram_adr = beat_adr_q[Aw-1:0];
    ram_we = commit ? sa_sel_i : '0;
  end

  // Acknowledge, error, beat address and snoop registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      beat_adr_q  <= '0;
      snoop_en_q  <= 1'b0;
      snoop_adr_q <= '0;
    end else begin
      ack_q       <= ack_d;
      err_q       <= err_d;
      beat_adr_q  <= beat_adr_d;
      snoop_en_q  <= commit;
      if (commit) snoop_adr_q <= beat_adr_q;
    end
  end

  wb_ram_sp_be #(.Dw(Dw), .Aw(Aw)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .adr  (ram_adr),
    .we   (ram_we),
    .wdat (sa_dat_i),
    .rdat (sa_dat_o)
  );

  assign sa_ack_o    = ack_q;
  assign sa_err_o    = err_q;
  assign sa_rty_o    = 1'b0;
  assign snoop_en_o  = SnoopOn & snoop_en_q;
  assign snoop_adr_o = snoop_adr_q;

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Self-checking bench for wb_burst_ram_slave: directed scenarios plus randomized classic/burst traffic.
// Reference memory and burst address sequence are modelled with plain arithmetic.
// Master always drives stb continuously; bursts end with cti=111.
module tb_wb_burst_ram_slave;
  import wb_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sa_adr_i, sa_dat_i;
  logic [3:0]  sa_sel_i;
  logic        sa_we_i, sa_stb_i, sa_cyc_i;
  logic [2:0]  sa_cti_i;
  logic [1:0]  sa_bte_i;
  logic [31:0] sa_dat_o, snoop_adr_o;
  logic        sa_ack_o, sa_err_o, sa_rty_o, snoop_en_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [4096];

  always #5 clk = ~clk;

  wb_burst_ram_slave #(.Dw(32), .Aw(12), .SNOOP_EN("ENABLED")) dut (
    .clk(clk), .rst(rst),
    .sa_adr_i(sa_adr_i), .sa_dat_i(sa_dat_i), .sa_sel_i(sa_sel_i), .sa_we_i(sa_we_i),
    .sa_stb_i(sa_stb_i), .sa_cyc_i(sa_cyc_i), .sa_cti_i(sa_cti_i), .sa_bte_i(sa_bte_i),
    .sa_dat_o(sa_dat_o), .sa_ack_o(sa_ack_o), .sa_err_o(sa_err_o), .sa_rty_o(sa_rty_o),
    .snoop_adr_o(snoop_adr_o), .snoop_en_o(snoop_en_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    sa_cyc_i = 1'b0; sa_stb_i = 1'b0; sa_we_i = 1'b0;
    sa_cti_i = CTI_CLASSIC; sa_bte_i = BTE_LINEAR; sa_sel_i = 4'h0;
    sa_adr_i = 32'd0; sa_dat_i = 32'd0;
  endtask

  // Wrapping bursts stay inside an aligned block of 4/8/16 words.
  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [1:0] bte);
    logic [31:0] sz;
    if (bte == BTE_LINEAR) return a + 32'd1;
    sz = 32'd4 << (int'(bte) - 1);
    return (a / sz) * sz + (a + 32'd1) % sz;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = dat[b*8 +: 8];
    return r;
  endfunction

  task automatic classic(input logic [31:0] adr, input bit we, input logic [31:0] dat, input logic [3:0] sel);
    bit oor;
    oor = (adr >= 32'h1000);
    sa_adr_i = adr; sa_dat_i = dat; sa_sel_i = sel; sa_we_i = we;
    sa_cti_i = CTI_CLASSIC; sa_bte_i = BTE_LINEAR; sa_cyc_i = 1'b1; sa_stb_i = 1'b1;
    step();
    chk("classic_ack", {31'd0, sa_ack_o}, {31'd0, !oor});
    chk("classic_err", {31'd0, sa_err_o}, {31'd0, oor});
    if (!we && !oor) chk("classic_rdata", sa_dat_o, mem_m[adr[11:0]]);
    step();
    idle_bus();
    if (we && !oor) mem_m[adr[11:0]] = merge(mem_m[adr[11:0]], dat, sel);
    chk("classic_ack_drop", {31'd0, sa_ack_o}, 32'd0);
    chk("classic_err_drop", {31'd0, sa_err_o}, 32'd0);
    chk("classic_snoop_en", {31'd0, snoop_en_o}, {31'd0, we && !oor});
    if (we && !oor) chk("classic_snoop_adr", snoop_adr_o, adr);
    step();
    chk("classic_snoop_clear", {31'd0, snoop_en_o}, 32'd0);
  endtask

  task automatic burst(input logic [31:0] start, input int n, input logic [1:0] bte, input bit we, input bit seq);
    logic [31:0] a, prev, d;
    a = start;
    prev = start;
    sa_adr_i = a; sa_we_i = we; sa_sel_i = 4'hF; sa_bte_i = bte;
    sa_cti_i = CTI_INC; sa_cyc_i = 1'b1; sa_stb_i = 1'b1; sa_dat_i = 32'd0;
    step();
    for (int i = 0; i < n; i++) begin
      chk("burst_ack", {31'd0, sa_ack_o}, 32'd1);
      chk("burst_err", {31'd0, sa_err_o}, 32'd0);
      if (!we) chk("burst_rdata", sa_dat_o, mem_m[a[11:0]]);
      if (we && i > 0) begin
        chk("burst_snoop_en", {31'd0, snoop_en_o}, 32'd1);
        chk("burst_snoop_adr", snoop_adr_o, prev);
      end else begin
        chk("burst_no_snoop", {31'd0, snoop_en_o}, 32'd0);
      end
      d = seq ? 32'(i + 1) : $urandom;
      sa_adr_i = a; sa_dat_i = d;
      sa_cti_i = (i == n - 1) ? CTI_EOB : CTI_INC;
      step();
      if (we) mem_m[a[11:0]] = d;
      prev = a;
      a = model_next(a, bte);
    end
    idle_bus();
    chk("burst_ack_end", {31'd0, sa_ack_o}, 32'd0);
    chk("burst_last_snoop", {31'd0, snoop_en_o}, {31'd0, we});
    if (we) chk("burst_last_snoop_adr", snoop_adr_o, prev);
    step();
    chk("burst_snoop_clear", {31'd0, snoop_en_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] d0, d1;
    int op, n;
    logic [1:0] bte;
    logic [31:0] st;

    // Reset state
    idle_bus();
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ack", {31'd0, sa_ack_o}, 32'd0);
    chk("rst_err", {31'd0, sa_err_o}, 32'd0);
    chk("rst_rty", {31'd0, sa_rty_o}, 32'd0);
    chk("rst_snoop_en", {31'd0, snoop_en_o}, 32'd0);
    chk("rst_snoop_adr", snoop_adr_o, 32'd0);
    chk("rst_dat", sa_dat_o, 32'd0);
    rst = 1'b0;
    step();

    // Classic write then read, then a single-byte write
    classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    classic(32'h10, 1'b0, 32'h0, 4'hF);
    classic(32'h10, 1'b1, 32'h0000AB00, 4'b0010);
    chk("byte_merge_model", mem_m[12'h10], 32'hDEADABEF);
    classic(32'h10, 1'b0, 32'h0, 4'hF);

    // Wrap8 read from 0x1D over a freshly written block
    burst(32'h18, 8, BTE_LINEAR, 1'b1, 1'b0);
    burst(32'h1D, 8, BTE_WRAP8, 1'b0, 1'b0);

    // Linear write burst 0x20..0x23 with data 1..4, read back
    burst(32'h20, 4, BTE_LINEAR, 1'b1, 1'b1);
    chk("seq_model", mem_m[12'h23], 32'd4);
    burst(32'h20, 4, BTE_LINEAR, 1'b0, 1'b0);

    // Out-of-range write aliasing onto word 0 must leave it untouched
    classic(32'h0, 1'b1, 32'h12345678, 4'hF);
    classic(32'h1000, 1'b1, 32'hFFFFFFFF, 4'hF);
    classic(32'h0, 1'b0, 32'h0, 4'hF);

    // Linear burst crossing the top of RAM
    sa_adr_i = 32'hFFF; sa_we_i = 1'b0; sa_sel_i = 4'hF; sa_bte_i = BTE_LINEAR;
    sa_cti_i = CTI_INC; sa_cyc_i = 1'b1; sa_stb_i = 1'b1;
    step();
    chk("top_first_ack", {31'd0, sa_ack_o}, 32'd1);
    step();
    chk("top_cross_ack", {31'd0, sa_ack_o}, 32'd0);
    chk("top_cross_err", {31'd0, sa_err_o}, 32'd1);
    idle_bus();
    step();
    chk("top_err_clear", {31'd0, sa_err_o}, 32'd0);
    chk("top_ack_clear", {31'd0, sa_ack_o}, 32'd0);

    // Reset asserted during beat 2 of a 4-beat write burst
    burst(32'h40, 4, BTE_LINEAR, 1'b1, 1'b0);
    d0 = $urandom; d1 = $urandom;
    sa_adr_i = 32'h40; sa_we_i = 1'b1; sa_sel_i = 4'hF; sa_bte_i = BTE_LINEAR;
    sa_cti_i = CTI_INC; sa_cyc_i = 1'b1; sa_stb_i = 1'b1; sa_dat_i = d0;
    step();
    chk("rstb_ack", {31'd0, sa_ack_o}, 32'd1);
    step();
    mem_m[12'h40] = d0;
    chk("rstb_snoop0", {31'd0, snoop_en_o}, 32'd1);
    sa_adr_i = 32'h41; sa_dat_i = d1; rst = 1'b1;
    step();
    chk("rstb_ack_low", {31'd0, sa_ack_o}, 32'd0);
    chk("rstb_snoop_low", {31'd0, snoop_en_o}, 32'd0);
    chk("rstb_snoop_adr", snoop_adr_o, 32'd0);
    rst = 1'b0;
    idle_bus();
    step();
    classic(32'h41, 1'b0, 32'h0, 4'hF);
    classic(32'h40, 1'b0, 32'h0, 4'hF);

    // Randomized traffic over a pre-filled 64-word region
    for (int k = 0; k < 4; k++) burst(32'h100 + 32'(k * 16), 16, BTE_LINEAR, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        classic(32'h100 + $urandom_range(0, 63), 1'b1, $urandom, 4'($urandom_range(0, 15)));
      end else if (op == 1) begin
        classic(32'h100 + $urandom_range(0, 63), 1'b0, 32'h0, 4'hF);
      end else begin
        bte = 2'($urandom_range(0, 3));
        n = int'($urandom_range(2, 8));
        if (bte == BTE_LINEAR) st = 32'h100 + $urandom_range(0, 63 - n);
        else                   st = 32'h100 + $urandom_range(0, 63);
        burst(st, n, bte, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
